// File: rtl/gfx_pkg.sv
// Shared types for the FP/int pipe and its issue scheduler.
package gfx_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned FPINT_STAGES = 15;

  typedef enum logic [3:0] {
    FpintNone,
    FpintAdd,
    FpintSub,
    FpintMul,
    FpintI2f,
    FpintF2i,
    FpintMin,
    FpintMax
  } fpint_func_e;

  // Stage-0 control word; all-zero means the pipe does nothing this cycle.
  typedef struct packed {
    logic        fp_en;
    fpint_func_e func;
    logic [2:0]  rnd_mode;
    logic        neg_a;
    logic        neg_b;
    logic        sat;
    logic [4:0]  dst_fmt;
  } fpint_op_t;

  localparam int unsigned FPINT_OP_W   = $bits(fpint_op_t);
  localparam fpint_op_t   FPINT_OP_NOP = '0;

  // Tag id is sized for up to 16 requesters; schedulers use the low bits.
  localparam int unsigned SCHED_ID_MAX_W = 4;

  typedef struct packed {
    logic                      valid;
    logic [SCHED_ID_MAX_W-1:0] id;
  } fpint_sched_tag_t;

  function automatic int unsigned sched_id_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/gfx_fpint_sched_fifo.sv
// Result FIFO for the FP/int scheduler: {word, requester id} entries.
module gfx_fpint_sched_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 32,
  parameter int unsigned IdW   = 1,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  input  logic [IdW-1:0]   id_i,
  input  logic             pop_i,
  output logic [DataW-1:0] data_o,
  output logic [IdW-1:0]   id_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [DataW-1:0] data_q [Depth];
  logic [IdW-1:0]   id_q   [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = data_q[rd_ptr_q];
  assign id_o    = id_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = (32'(wr_ptr_q) == Depth - 1) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (32'(rd_ptr_q) == Depth - 1) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      data_q[wr_ptr_q] <= data_i;
      id_q[wr_ptr_q]   <= id_i;
    end
  end

`ifndef SYNTHESIS
  // Credits make overflow impossible; a push while full is a scheduler bug.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && full_o)) else $error("result fifo pushed while full");
    end
  end
`endif

endmodule

// File: rtl/gfx_fpint_sched.sv
// Round-robin, credit-based issue scheduler for the non-stallable FP/int pipe.
module gfx_fpint_sched
  import gfx_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned LATENCY    = FPINT_STAGES,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned IdW       = sched_id_w(NUM_REQ),
  localparam int unsigned CredW     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]       req_a,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]       req_b,
  input  logic [NUM_REQ-1:0][FPINT_OP_W-1:0]   req_op,
  output logic [WORD_W-1:0]                    fpint_a,
  output logic [WORD_W-1:0]                    fpint_b,
  output logic [FPINT_OP_W-1:0]                fpint_op,
  input  logic [WORD_W-1:0]                    fpint_q,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WORD_W-1:0]                    out_q,
  output logic [IdW-1:0]                       out_id
);

  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);

  logic [CredW-1:0]                credits_q, credits_d;
  logic [IdW-1:0]                  rr_ptr_q, rr_ptr_d;
  fpint_sched_tag_t [LATENCY-1:0]  trk_q, trk_d;

  logic             gnt_found;
  logic [IdW-1:0]   gnt_idx;
  logic [31:0]      cand;
  logic             issue, pop, push;
  logic             fifo_full, fifo_empty;
  logic [FifoCntW-1:0] fifo_cnt;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!gnt_found && req_valid[cand[IdW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IdW-1:0];
      end
    end
  end

  // Registered credits only: a same-cycle pop cannot unblock issue.
  assign issue     = !rst && (credits_q != '0) && gnt_found;
  assign req_ready = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign pop       = out_valid && out_ready;
  assign push      = trk_q[LATENCY-1].valid;

  always_comb begin
    fpint_a  = '0;
    fpint_b  = '0;
    fpint_op = FPINT_OP_NOP;
    if (issue) begin
      fpint_a  = req_a[gnt_idx];
      fpint_b  = req_b[gnt_idx];
      fpint_op = req_op[gnt_idx];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IdW'(1);
    end
  end

  always_comb begin
    credits_d = credits_q;
    unique case ({issue, pop})
      2'b10:   credits_d = credits_q - CredW'(1);
      2'b01:   credits_d = credits_q + CredW'(1);
      default: credits_d = credits_q;
    endcase
  end

  // Tag enters on the issue cycle and leaves as fpint_q carries its result.
  always_comb begin
    trk_d          = trk_q;
    trk_d[0].valid = issue;
    trk_d[0].id    = issue ? SCHED_ID_MAX_W'(gnt_idx) : '0;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      trk_d[i] = trk_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= CredW'(FIFO_DEPTH);
      rr_ptr_q  <= '0;
      trk_q     <= '0;
    end else begin
      credits_q <= credits_d;
      rr_ptr_q  <= rr_ptr_d;
      trk_q     <= trk_d;
    end
  end

  gfx_fpint_sched_fifo #(
    .Depth (FIFO_DEPTH),
    .DataW (WORD_W),
    .IdW   (IdW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (fpint_q),
    .id_i    (trk_q[LATENCY-1].id[IdW-1:0]),
    .pop_i   (pop),
    .data_o  (out_q),
    .id_o    (out_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign out_valid = !fifo_empty;

`ifndef SYNTHESIS
  int unsigned inflight;

  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight += 32'(trk_q[i].valid);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (32'(credits_q) + inflight + 32'(fifo_cnt) == FIFO_DEPTH)
        else $error("credit invariant broken");
      assert ((trk_q[LATENCY-1].id >> IdW) == '0)
        else $error("tag id out of range");
      assert (!(push && fifo_full)) else $error("push into full result fifo");
    end
  end
`endif

endmodule

// File: tb/tb_gfx_fpint_sched.sv
// Directed bench for gfx_fpint_sched with a delay-line model of the pipe.
module tb_gfx_fpint_sched;
  import gfx_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned LAT     = FPINT_STAGES;
  localparam int unsigned DEPTH   = 4;

  logic                               clk = 1'b0;
  logic                               rst;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][WORD_W-1:0]     req_a;
  logic [NUM_REQ-1:0][WORD_W-1:0]     req_b;
  logic [NUM_REQ-1:0][FPINT_OP_W-1:0] req_op;
  logic [WORD_W-1:0]                  fpint_a;
  logic [WORD_W-1:0]                  fpint_b;
  logic [FPINT_OP_W-1:0]              fpint_op;
  logic [WORD_W-1:0]                  fpint_q;
  logic                               out_valid;
  logic                               out_ready;
  logic [WORD_W-1:0]                  out_q;
  logic [0:0]                         out_id;

  gfx_fpint_sched #(
    .NUM_REQ    (NUM_REQ),
    .LATENCY    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .fpint_a   (fpint_a),
    .fpint_b   (fpint_b),
    .fpint_op  (fpint_op),
    .fpint_q   (fpint_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  // Pipe model: a+b delayed by LAT cycles.
  logic [WORD_W-1:0] pipe_q [LAT];
  assign fpint_q = pipe_q[LAT-1];

  always @(posedge clk) begin
    pipe_q[0] <= fpint_a + fpint_b;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  typedef struct packed {
    logic [WORD_W-1:0] q;
    logic              id;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   out_ids[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_issue = 0;
  bit   saw_valid = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample comb outputs, track issues/pops, then advance.
  task automatic tick(input bit chk, input logic [NUM_REQ-1:0] exp_rdy);
    exp_t e;
    #1;
    if (chk) check("req_ready", req_ready, exp_rdy);
    if (!rst) begin
      if (req_ready == '0) begin
        check("bubble_zero", {fpint_op, fpint_a, fpint_b}, '0);
      end else begin
        int g = req_ready[1] ? 1 : 0;
        check("ready_onehot", $onehot(req_ready) && ((req_ready & ~req_valid) == '0), 1);
        check("issue_mux", {fpint_op, fpint_a, fpint_b}, {req_op[g], req_a[g], req_b[g]});
        sb.push_back({req_a[g] + req_b[g], g[0]});
        grants.push_back(g);
        n_issue++;
      end
      if (out_valid) saw_valid = 1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_q", out_q, e.q);
          check("out_id", out_id, e.id);
          out_ids.push_back(int'(out_id));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tracking();
    sb.delete();
    grants.delete();
    out_ids.delete();
    n_issue = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    tick(0, '0);
    rst = 1'b0;
    clear_tracking();
  endtask

  task automatic drain();
    req_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) tick(0, '0);
    check("drained", sb.size(), 0);
    check("drained_valid", out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    @(posedge clk);
    #1;

    // Reset: no grant while rst is high, nothing to output.
    req_valid = 2'b11;
    tick(1, 2'b00);
    tick(1, 2'b00);
    check("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    req_valid = '0;
    tick(1, 2'b00);
    check("idle_out_valid", out_valid, 0);

    // Single op: result visible LAT+1 cycles after issue.
    out_ready = 1'b1;
    req_a[0] = 32'd1;
    req_b[0] = 32'd2;
    req_op[0] = 16'h9a35;
    req_valid = 2'b01;
    saw_valid = 0;
    tick(1, 2'b01);
    req_valid = '0;
    repeat (LAT) tick(1, 2'b00);
    check("single_early", saw_valid, 0);
    check("single_valid", out_valid, 1);
    check("single_q", out_q, 3);
    check("single_id", out_id, 0);
    tick(0, '0);
    check("single_popped", out_valid, 0);

    // Round-robin: grants alternate, stalling on credits after four.
    do_reset();
    req_a[0] = 32'd10;
    req_b[0] = 32'd1;
    req_a[1] = 32'd20;
    req_b[1] = 32'd2;
    req_op[0] = 16'h1111;
    req_op[1] = 16'h2222;
    out_ready = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 80 && n_issue < 6; i++) tick(0, '0);
    check("rr_issues", n_issue, 6);
    for (int k = 0; k < 6 && k < grants.size(); k++) check("rr_grant", grants[k], k % 2);
    drain();
    check("rr_outs", out_ids.size(), 6);
    for (int k = 0; k < 6 && k < out_ids.size(); k++) check("rr_out_id", out_ids[k], k % 2);

    // Backpressure: four issues then blocked.
    do_reset();
    req_op[0] = 16'h0f0f;
    req_valid = 2'b01;
    for (int i = 0; i < 30; i++) begin
      req_a[0] = 32'(100 + i);
      req_b[0] = 32'(i);
      tick(0, '0);
    end
    check("bp_issues", n_issue, 4);
    check("bp_head_q", out_q, 100);
    check("bp_head_id", out_id, 0);

    // Stall: head stays put, no issue.
    for (int i = 0; i < 5; i++) begin
      tick(1, 2'b00);
      check("stall_valid", out_valid, 1);
      check("stall_q", out_q, 100);
      check("stall_id", out_id, 0);
    end

    // Credit edge: pop and request together; issue only next cycle.
    req_a[0] = 32'd500;
    req_b[0] = 32'd5;
    out_ready = 1'b1;
    tick(1, 2'b00);
    out_ready = 1'b0;
    tick(1, 2'b01);
    tick(1, 2'b00);
    check("edge_issues", n_issue, 5);

    // Resume: pop then issue one cycle later, streaming while pops return.
    out_ready = 1'b1;
    tick(1, 2'b00);
    tick(1, 2'b01);
    tick(1, 2'b01);
    tick(1, 2'b01);
    tick(1, 2'b00);
    drain();
    check("bp_total_out", out_ids.size(), 8);

    // Reset mid-flight: in-flight results are dropped.
    do_reset();
    out_ready = 1'b1;
    req_a[0] = 32'd7;
    req_b[0] = 32'd7;
    req_a[1] = 32'd9;
    req_b[1] = 32'd9;
    req_valid = 2'b11;
    tick(1, 2'b01);
    tick(1, 2'b10);
    tick(1, 2'b01);
    req_valid = '0;
    repeat (4) tick(0, '0);
    rst = 1'b1;
    tick(0, '0);
    rst = 1'b0;
    clear_tracking();
    saw_valid = 0;
    repeat (LAT + 5) tick(1, 2'b00);
    check("flight_dropped", saw_valid, 0);
    out_ready = 1'b0;
    req_a[0] = 32'd40;
    req_b[0] = 32'd2;
    req_valid = 2'b01;
    repeat (8) tick(0, '0);
    check("flight_credits", n_issue, 4);
    drain();
    check("flight_outs", out_ids.size(), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
